// File: rtl/posit_encoder.sv
// Serially packs a normalized product (sign, regime k, 3-bit exp, 64-bit mantissa) into a 32-bit ES=3 posit.
// Fixed 35-cycle done->valid latency; result held on valid until ack, done_in ignored while busy.
module posit_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        done_in,
    input  logic [63:0] mant_in,
    input  logic [2:0]  exp_in,
    input  logic [5:0]  k_in,
    input  logic        sign_in,
    output logic        recieved,
    output logic [31:0] posit_out,
    output logic        valid,
    input  logic        ack,
    output logic        busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_BUILD, S_ROUND, S_SIGN, S_OUT
    } state_t;

    state_t      r_state, w_next;
    logic        r_armed;
    logic [63:0] r_mant;
    logic [2:0]  r_exp;
    logic [5:0]  r_k;
    logic        r_sign;
    logic [4:0]  r_cnt;
    logic [30:0] r_body;

    logic [6:0]   w_k_ext;
    logic [6:0]   w_run_len;
    logic [127:0] w_tail;
    logic [127:0] w_stream;
    logic         w_guard;
    logic         w_sticky;
    logic [31:0]  w_inc;
    logic [30:0]  w_rounded;
    logic [31:0]  w_posit;

    // Whole bit stream, MSB = stream position 0: regime run, terminator, exp, fraction, zeros.
    assign w_k_ext   = {r_k[5], r_k};
    assign w_run_len = r_k[5] ? (7'd0 - w_k_ext) : (w_k_ext + 7'd1);
    assign w_tail    = {r_k[5], r_exp, r_mant[61:0], 62'd0};
    assign w_stream  = (r_k[5] ? 128'd0 : ~({128{1'b1}} >> w_run_len)) | (w_tail >> w_run_len);
    assign w_guard   = w_stream[96];
    assign w_sticky  = |w_stream[95:0];
    assign w_inc     = {1'b0, r_body} + 32'd1;
    assign w_posit   = r_sign ? (~{1'b0, r_body} + 32'd1) : {1'b0, r_body};

    always_comb begin
        w_rounded = r_body;
        if (w_guard && (w_sticky || r_body[0]))
            w_rounded = w_inc[31] ? 31'h7FFF_FFFF : w_inc[30:0];
        if (r_mant == 64'd0)
            w_rounded = 31'd0;
        else if (!r_k[5] && (r_k[4:0] >= 5'd30))
            w_rounded = 31'h7FFF_FFFF;
        else if (r_k[5] && (r_k[4:0] <= 5'd1))
            w_rounded = 31'd1;
        else if (w_rounded == 31'd0)
            w_rounded = 31'd1;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (done_in && r_armed) w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_BUILD;
            S_BUILD:   if (r_cnt == 5'd30) w_next = S_ROUND;
            S_ROUND:   w_next = S_SIGN;
            S_SIGN:    w_next = S_OUT;
            S_OUT:     if (ack) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_armed   <= 1'b1;
            r_mant    <= 64'd0;
            r_exp     <= 3'd0;
            r_k       <= 6'd0;
            r_sign    <= 1'b0;
            r_cnt     <= 5'd0;
            r_body    <= 31'd0;
            recieved  <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            posit_out <= 32'd0;
        end else begin
            r_state  <= w_next;
            recieved <= (w_next == S_CAPTURE);
            valid    <= (w_next == S_OUT);
            busy     <= (w_next != S_IDLE);
            // Armed only re-arms after done_in is seen low, so the trailing done cycle cannot re-capture.
            if (r_state == S_CAPTURE)
                r_armed <= 1'b0;
            else if (!done_in)
                r_armed <= 1'b1;
            case (r_state)
                S_CAPTURE: begin
                    r_mant <= mant_in;
                    r_exp  <= exp_in;
                    r_k    <= k_in;
                    r_sign <= sign_in;
                    r_cnt  <= 5'd0;
                end
                S_BUILD: begin
                    r_body[5'd30 - r_cnt] <= w_stream[7'd127 - {2'b00, r_cnt}];
                    r_cnt <= r_cnt + 5'd1;
                end
                S_ROUND: r_body <= w_rounded;
                S_SIGN:  posit_out <= w_posit;
                default: ;
            endcase
        end
    end
endmodule
